// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect, misalignment suppression and stall timeout.
// Optional forwarding outputs (fwd_en/fwd_rd/fwd_data) are built only when EXMEM_FWD_EN is defined.
module ex_mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_c,
  input  logic        ex_zero,
  input  logic        ex_branch,
  input  logic        ex_jump,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_funct3,
  input  logic        mem_ready,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mem_valid,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  output logic [4:0]  mem_rd,
  output logic        misalign,
  output logic        timeout_err
`ifdef EXMEM_FWD_EN
  ,
  output logic        fwd_en,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  logic        r_mem_valid;
  logic        r_mem_regwrite;
  logic        r_mem_memread;
  logic        r_mem_memwrite;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_mem_funct3;
  logic [4:0]  r_mem_rd;
  logic        r_misalign;
  logic        r_timeout_err;
  logic [7:0]  r_stall_cnt;

  logic        w_pending;
  logic        w_stall;
  logic        w_taken;
  logic        w_is_mem;
  logic        w_half_bad;
  logic        w_word_bad;
  logic        w_misalign;
  logic [31:0] w_addr_next;
  logic [7:0]  w_cnt_next;

  assign w_pending = r_mem_valid & (r_mem_memread | r_mem_memwrite) & ~r_misalign;
  assign w_stall   = w_pending & ~mem_ready;

  assign w_taken        = ex_jump | (ex_branch & ex_zero);
  assign redirect_valid = rstn & ex_valid & ~w_stall & w_taken;
  assign redirect_pc    = ex_pc + ex_imm;

  // Only real memory accesses are size-checked; ALU results may be any value.
  assign w_is_mem    = ex_memread | ex_memwrite;
  assign w_half_bad  = (ex_funct3[1:0] == 2'b01) & ex_alu_c[0];
  assign w_word_bad  = (ex_funct3[1:0] == 2'b10) & (ex_alu_c[1:0] != 2'b00);
  assign w_misalign  = ex_valid & w_is_mem & (w_half_bad | w_word_bad);
  assign w_addr_next = ex_jump ? (ex_pc + 32'd4) : ex_alu_c;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem_valid    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_addr     <= 32'd0;
      r_mem_wdata    <= 32'd0;
      r_mem_funct3   <= 3'd0;
      r_mem_rd       <= 5'd0;
      r_misalign     <= 1'b0;
    end else if (!w_stall) begin
      if (ex_valid) begin
        r_mem_valid    <= 1'b1;
        r_mem_regwrite <= ex_regwrite & ~ex_branch & ~w_misalign;
        r_mem_memread  <= ex_memread & ~w_misalign;
        r_mem_memwrite <= ex_memwrite & ~w_misalign;
        r_mem_addr     <= w_addr_next;
        r_mem_wdata    <= ex_wdata;
        r_mem_funct3   <= ex_funct3;
        r_mem_rd       <= ex_rd;
        r_misalign     <= w_misalign;
      end else begin
        r_mem_valid    <= 1'b0;
        r_mem_regwrite <= 1'b0;
        r_mem_memread  <= 1'b0;
        r_mem_memwrite <= 1'b0;
        r_mem_addr     <= 32'd0;
        r_mem_wdata    <= 32'd0;
        r_mem_funct3   <= 3'd0;
        r_mem_rd       <= 5'd0;
        r_misalign     <= 1'b0;
      end
    end
  end

  always_comb begin
    w_cnt_next = 8'd0;
    if (w_stall) begin
      w_cnt_next = (r_stall_cnt >= LP_TIMEOUT) ? LP_TIMEOUT : (r_stall_cnt + 8'd1);
    end
  end

  // The error flag rises on the same edge the counter reaches the limit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt   <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_stall_cnt   <= w_cnt_next;
      r_timeout_err <= r_timeout_err | (w_cnt_next == LP_TIMEOUT);
    end
  end

  assign stall        = w_stall;
  assign mem_valid    = r_mem_valid;
  assign mem_regwrite = r_mem_regwrite;
  assign mem_memread  = r_mem_memread;
  assign mem_memwrite = r_mem_memwrite;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_funct3   = r_mem_funct3;
  assign mem_rd       = r_mem_rd;
  assign misalign     = r_misalign;
  assign timeout_err  = r_timeout_err;

`ifdef EXMEM_FWD_EN
  assign fwd_en   = r_mem_valid & r_mem_regwrite & ~r_mem_memread & (r_mem_rd != 5'd0);
  assign fwd_rd   = r_mem_rd;
  assign fwd_data = r_mem_addr;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes expected retirements, a monitor pops them.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, ex_zero, ex_branch, ex_jump;
  logic [31:0] ex_alu_c, ex_pc, ex_imm, ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic [2:0]  ex_funct3;
  logic        mem_ready;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic        misalign, timeout_err;
`ifdef EXMEM_FWD_EN
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_ret = 0;
  logic [75:0] exp_q[$];
  logic [75:0] mon_exp, mon_act;

  always #5 clk = ~clk;

  ex_mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_alu_c(ex_alu_c), .ex_zero(ex_zero),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_wdata(ex_wdata), .ex_funct3(ex_funct3),
    .mem_ready(mem_ready), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rd(mem_rd),
    .misalign(misalign), .timeout_err(timeout_err)
`ifdef EXMEM_FWD_EN
    , .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  function automatic logic [75:0] pk(input logic [31:0] a, input logic [31:0] w,
                                     input logic [4:0] rd, input logic [2:0] f3,
                                     input logic rw, input logic mr, input logic mw,
                                     input logic mis);
    return {a, w, rd, f3, rw, mr, mw, mis};
  endfunction

  task automatic drive(input logic v, input logic [31:0] c, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [31:0] wd, input logic [2:0] f3, input logic br,
                       input logic jp, input logic zr, input logic [31:0] pc,
                       input logic [31:0] imm);
    ex_valid = v; ex_alu_c = c; ex_rd = rd; ex_regwrite = rw; ex_memread = mr;
    ex_memwrite = mw; ex_wdata = wd; ex_funct3 = f3; ex_branch = br; ex_jump = jp;
    ex_zero = zr; ex_pc = pc; ex_imm = imm;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h77, 5'd13, 1'b1, 1'b1, 1'b0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an entry retires in the cycle it is valid and not stalled.
  always @(negedge clk) begin
    if (rstn === 1'b1 && mem_valid === 1'b1 && stall === 1'b0) begin
      n_cmp++;
      n_ret++;
      mon_act = {mem_addr, mem_wdata, mem_rd, mem_funct3, mem_regwrite, mem_memread,
                 mem_memwrite, misalign};
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL retire: unexpected entry 0x%019h, nothing expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL retire: got 0x%019h expected 0x%019h", mon_act, mon_exp);
        end else begin
          $display("retire %0d: addr=0x%08h rd=%0d f3=%0d rw/mr/mw/mis=%b", n_ret,
                   mem_addr, mem_rd, mem_funct3,
                   {mem_regwrite, mem_memread, mem_memwrite, misalign});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    mem_ready = 1'b1;
    // Taken jump held during reset must not redirect.
    drive(1'b1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h10, 32'h20);
    tick(); tick();
    @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_redirect", 32'(redirect_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);

    // add: result 0x10 to x5
    tick(); rstn = 1'b1;
    drive(1'b1, 32'h10, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h10, 32'h0, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));

    // jal at 0x200, imm 0x40: link value pc+4
    tick();
    drive(1'b1, 32'hDEAD, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40);
    exp_q.push_back(pk(32'h204, 32'h0, 5'd1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check("add_mem_addr", mem_addr, 32'h10);
    check("add_mem_valid", 32'(mem_valid), 32'd1);
    check("add_stall", 32'(stall), 32'd0);
    check("jal_redirect", 32'(redirect_valid), 32'd1);
    check("jal_redirect_pc", redirect_pc, 32'h240);

    // bne taken, backwards target wraps to 0xF0
    tick();
    drive(1'b1, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 32'h100, 32'hFFFFFFF0);
    exp_q.push_back(pk(32'h1, 32'h0, 5'd3, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check("bne_redirect", 32'(redirect_valid), 32'd1);
    check("bne_redirect_pc", redirect_pc, 32'h000000F0);

    // branch not taken
    tick();
    drive(1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h300, 32'h8);
    exp_q.push_back(pk(32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check("bnt_redirect", 32'(redirect_valid), 32'd0);

    // misaligned word store with memory not ready: suppressed, never stalls
    tick(); mem_ready = 1'b0;
    drive(1'b1, 32'h1002, 5'd0, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h1002, 32'hCAFEBABE, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1));

    // misaligned half load
    tick();
    drive(1'b1, 32'h2001, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h2001, 32'h0, 5'd6, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    check("mis_st_stall", 32'(stall), 32'd0);
    check("mis_st_misalign", 32'(misalign), 32'd1);
    check("mis_st_memwrite", 32'(mem_memwrite), 32'd0);

    // aligned unsigned half load
    tick(); mem_ready = 1'b1;
    drive(1'b1, 32'h2002, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0, 3'b101, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h2002, 32'h0, 5'd7, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("mis_ld_misalign", 32'(misalign), 32'd1);
    check("mis_ld_stall", 32'(stall), 32'd0);

    // byte load at odd address is legal
    tick();
    drive(1'b1, 32'h2003, 5'd12, 1'b1, 1'b1, 1'b0, 32'h0, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h2003, 32'h0, 5'd12, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0));

    // word load at 0x1000, memory not ready for three cycles
    tick();
    drive(1'b1, 32'h1000, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h1000, 32'h0, 5'd8, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("byte_misalign", 32'(misalign), 32'd0);

    // taken branch waits behind the stall
    tick(); mem_ready = 1'b0;
    drive(1'b1, 32'h55, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h400, 32'h10);
    exp_q.push_back(pk(32'h55, 32'h0, 5'd9, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_stall", 32'(stall), 32'd1);
      check("ld_redirect_held", 32'(redirect_valid), 32'd0);
      check("ld_addr_held", mem_addr, 32'h1000);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("ld_release_stall", 32'(stall), 32'd0);
    check("ld_release_redirect", 32'(redirect_valid), 32'd1);
    check("ld_release_pc", redirect_pc, 32'h410);

    tick(); bubble();
    @(negedge clk);
    check("short_stall_no_timeout", 32'(timeout_err), 32'd0);
    tick();
    @(negedge clk);
    check("bubble_valid", 32'(mem_valid), 32'd0);
    check("bubble_ctrl", {29'd0, mem_regwrite, mem_memread, mem_memwrite}, 32'd0);
    check("bubble_stall", 32'(stall), 32'd0);

    // load at 0x3000 stalls past the limit of 4 cycles
    tick();
    drive(1'b1, 32'h3000, 5'd10, 1'b1, 1'b1, 1'b0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h3000, 32'h0, 5'd10, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(); mem_ready = 1'b0; bubble();
    for (int k = 1; k <= 6; k++) begin
      tick();
      @(negedge clk);
      check("to_stall", 32'(stall), 32'd1);
      check("to_err", 32'(timeout_err), (k >= 4) ? 32'd1 : 32'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("to_release_stall", 32'(stall), 32'd0);
    tick();
    @(negedge clk);
    check("to_sticky", 32'(timeout_err), 32'd1);

    // reset in the middle of a stalled load abandons it
    drive(1'b1, 32'h4000, 5'd11, 1'b1, 1'b1, 1'b0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); mem_ready = 1'b0;
    drive(1'b1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h500, 32'h8);
    @(negedge clk);
    check("mid_stall", 32'(stall), 32'd1);
    tick(); rstn = 1'b0;
    tick();
    @(negedge clk);
    check("rst2_stall", 32'(stall), 32'd0);
    check("rst2_mem_valid", 32'(mem_valid), 32'd0);
    check("rst2_timeout", 32'(timeout_err), 32'd0);
    check("rst2_mem_addr", mem_addr, 32'd0);
    check("rst2_mem_rd", 32'(mem_rd), 32'd0);
    check("rst2_redirect", 32'(redirect_valid), 32'd0);

    // adds to x0 and x7 for the forwarding path
    tick(); rstn = 1'b1; mem_ready = 1'b1;
    drive(1'b1, 32'h99, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h99, 32'h0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    drive(1'b1, 32'h1234, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(pk(32'h1234, 32'h0, 5'd7, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef EXMEM_FWD_EN
    @(negedge clk);
    check("fwd_rd0_en", 32'(fwd_en), 32'd0);
`endif
    tick(); bubble();
`ifdef EXMEM_FWD_EN
    @(negedge clk);
    check("fwd_rd7_en", 32'(fwd_en), 32'd1);
    check("fwd_rd7_rd", 32'(fwd_rd), 32'd7);
    check("fwd_rd7_data", fwd_data, 32'h1234);
`endif
    tick(); tick();
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
